// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit sitting between the control FSM's MEM state and a
// valid/ready data-memory bus with a variable-latency response channel.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   dmem_rd           : load strobe (funct3 selects LB/LH/LW/LBU/LHU)
//   dmem_we[3:0]      : store strobe, unshifted byte mask (0001/0011/1111)
//   funct3, addr      : load type and byte address
//   wdata             : right-aligned store data
//   mem_req_*         : bus request channel (word address, shifted strobe/data)
//   mem_rsp_*         : bus response channel (loads only)
//   lsu_busy          : access in flight (REQ, RESP, DONE)
//   lsu_done/lsu_err  : one-cycle completion pulse, err qualifies it
//   load_data         : extended load result, updated only on a good load
module dmem_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_rd,
    input  logic [3:0]  dmem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] load_data
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Last counter value before the access is aborted: REQ/RESP may last
    // exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;

    logic             mem_req_valid_q, mem_req_valid_d;
    logic [31:0]      mem_req_addr_q, mem_req_addr_d;
    logic [3:0]       mem_req_we_q, mem_req_we_d;
    logic [31:0]      mem_req_wdata_q, mem_req_wdata_d;
    logic             lsu_busy_q, lsu_busy_d;
    logic             lsu_done_q, lsu_done_d;
    logic             lsu_err_q, lsu_err_d;
    logic [31:0]      load_data_q, load_data_d;

    // Request decode (combinational on the IDLE-cycle inputs)
    logic        req_any, ld_ok, st_ok, is_half, is_word, illegal;
    logic [31:0] rsp_shift;
    logic [15:0] rsp_half;
    logic [31:0] ext_data;

    always_comb begin
        req_any = dmem_rd || (dmem_we != 4'b0000);
        ld_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
        st_ok   = (dmem_we == 4'b0001) || (dmem_we == 4'b0011) || (dmem_we == 4'b1111);
        is_half = dmem_rd ? (funct3[1:0] == 2'b01) : (dmem_we == 4'b0011);
        is_word = dmem_rd ? (funct3 == 3'b010)     : (dmem_we == 4'b1111);
        illegal = (dmem_rd && (dmem_we != 4'b0000)) ||
                  (dmem_rd && !ld_ok) || (!dmem_rd && !st_ok) ||
                  (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end

    // Lane select and extension of the response word
    always_comb begin
        rsp_shift = mem_rsp_rdata >> {lane_q, 3'b000};
        rsp_half  = lane_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            3'b001:  ext_data = {{16{rsp_half[15]}}, rsp_half};
            3'b100:  ext_data = {24'h0, rsp_shift[7:0]};
            3'b101:  ext_data = {16'h0, rsp_half};
            default: ext_data = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_load_d       = is_load_q;
        funct3_d        = funct3_q;
        lane_d          = lane_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_wdata_d = mem_req_wdata_q;
        load_data_d     = load_data_q;
        lsu_done_d      = 1'b0;
        lsu_err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    is_load_d = dmem_rd;
                    funct3_d  = funct3;
                    lane_d    = addr[1:0];
                    if (illegal) begin
                        state_d    = DONE;
                        lsu_done_d = 1'b1;
                        lsu_err_d  = 1'b1;
                    end else begin
                        // Bus fields are fixed here and held until the handshake
                        state_d         = REQ;
                        cnt_d           = '0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {addr[31:2], 2'b00};
                        mem_req_we_d    = dmem_rd ? 4'b0000 : 4'(dmem_we << addr[1:0]);
                        mem_req_wdata_d = wdata << {addr[1:0], 3'b000};
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (is_load_q) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d    = DONE;
                        lsu_done_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = DONE;
                    lsu_done_d      = 1'b1;
                    lsu_err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (mem_rsp_valid) begin
                    load_data_d = ext_data;
                    state_d     = DONE;
                    lsu_done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    lsu_done_d = 1'b1;
                    lsu_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;  // DONE: single-cycle completion
        endcase

        lsu_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_load_q       <= 1'b0;
            funct3_q        <= 3'b000;
            lane_q          <= 2'b00;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_we_q    <= '0;
            mem_req_wdata_q <= '0;
            lsu_busy_q      <= 1'b0;
            lsu_done_q      <= 1'b0;
            lsu_err_q       <= 1'b0;
            load_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_load_q       <= is_load_d;
            funct3_q        <= funct3_d;
            lane_q          <= lane_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            lsu_busy_q      <= lsu_busy_d;
            lsu_done_q      <= lsu_done_d;
            lsu_err_q       <= lsu_err_d;
            load_data_q     <= load_data_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign lsu_busy      = lsu_busy_q;
    assign lsu_done      = lsu_done_q;
    assign lsu_err       = lsu_err_q;
    assign load_data     = load_data_q;

endmodule
